// File: rtl/mos6502s_operand_fetcher.sv
// rtl/mos6502s_operand_fetcher.sv - 6502 operand/pointer byte fetch sequencer
//
// Reads the operand bytes of an instruction (and, for the indirect modes, the
// pointer bytes) over a req/ack memory bus and presents them to the
// effective-address generator together with the advanced PC.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                begin a fetch (sampled only when idle)
//   mode_i, pc_i, x_reg_i  addressing mode, first operand address, X index
//   mem_req_o, mem_addr_o  read request and its address
//   mem_ack_i, mem_rdata_i read completion and data
//   operand_lo_o/hi_o      fetched operand bytes
//   indirect_lo_o/hi_o     fetched pointer target bytes
//   pc_next_o              pc + operand byte count
//   busy_o, done_o         fetch in progress, one-cycle completion pulse
module mos6502s_operand_fetcher #(
  parameter bit JMP_IND_BUG = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [3:0]  mode_i,
  input  logic [15:0] pc_i,
  input  logic [7:0]  x_reg_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [7:0]  operand_lo_o,
  output logic [7:0]  operand_hi_o,
  output logic [7:0]  indirect_lo_o,
  output logic [7:0]  indirect_hi_o,
  output logic [15:0] pc_next_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [3:0] MODE_JMP_IND = 4'h9;  // (abs)
  localparam logic [3:0] MODE_ZPX_IND = 4'hA;  // (zp,X)
  localparam logic [3:0] MODE_ZPY_IND = 4'hB;  // (zp),Y - Y applied downstream

  typedef enum logic [2:0] {
    S_IDLE, S_OP_LO, S_OP_HI, S_PTR_LO, S_PTR_HI
  } state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic [15:0] pc_q, pc_next_q;
  logic [7:0]  x_q;
  logic [3:0]  mode_q;
  logic [7:0]  op_lo_q, op_hi_q, ind_lo_q, ind_hi_q;

  logic [7:0]  zp_base, zp_next, lo_inc;
  logic [15:0] ptr_lo_addr, ptr_hi_addr;

  function automatic logic [1:0] op_bytes(input logic [3:0] m);
    case (m)
      4'h2, 4'h3, 4'h4, 4'h5, 4'hA, 4'hB, 4'hC: op_bytes = 2'd1;
      4'h6, 4'h7, 4'h8, 4'h9:                   op_bytes = 2'd2;
      default:                                  op_bytes = 2'd0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; done is raised on the transition back to IDLE
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (op_bytes(mode_i) == 2'd0) done_d  = 1'b1;
          else                          state_d = S_OP_LO;
        end
      end
      S_OP_LO: begin
        if (mem_ack_i) begin
          if (op_bytes(mode_q) == 2'd2) begin
            state_d = S_OP_HI;
          end else if (mode_q == MODE_ZPX_IND || mode_q == MODE_ZPY_IND) begin
            state_d = S_PTR_LO;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_OP_HI: begin
        if (mem_ack_i) begin
          if (mode_q == MODE_JMP_IND) begin
            state_d = S_PTR_LO;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_PTR_LO: begin
        if (mem_ack_i) state_d = S_PTR_HI;
      end
      S_PTR_HI: begin
        if (mem_ack_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer addresses: zero-page pointers wrap inside page 0, and the NMOS
  // JMP (abs) bug keeps the high-byte read inside the pointer's page.
  always_comb begin
    zp_base     = (mode_q == MODE_ZPX_IND) ? op_lo_q + x_q : op_lo_q;
    zp_next     = zp_base + 8'd1;
    lo_inc      = op_lo_q + 8'd1;
    ptr_lo_addr = {8'h00, zp_base};
    ptr_hi_addr = {8'h00, zp_next};
    if (mode_q == MODE_JMP_IND) begin
      ptr_lo_addr = {op_hi_q, op_lo_q};
      ptr_hi_addr = JMP_IND_BUG ? {op_hi_q, lo_inc} : {op_hi_q, op_lo_q} + 16'd1;
    end
  end

  // Output logic
  always_comb begin
    mem_req_o  = (state_q != S_IDLE);
    busy_o     = (state_q != S_IDLE);
    mem_addr_o = 16'h0000;
    case (state_q)
      S_OP_LO:  mem_addr_o = pc_q;
      S_OP_HI:  mem_addr_o = pc_q + 16'd1;
      S_PTR_LO: mem_addr_o = ptr_lo_addr;
      S_PTR_HI: mem_addr_o = ptr_hi_addr;
      default:  mem_addr_o = 16'h0000;
    endcase
  end

  // Datapath: latch request on accept, capture read data on each ack
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= 16'h0000;
      pc_next_q <= 16'h0000;
      x_q       <= 8'h00;
      mode_q    <= 4'h0;
      op_lo_q   <= 8'h00;
      op_hi_q   <= 8'h00;
      ind_lo_q  <= 8'h00;
      ind_hi_q  <= 8'h00;
    end else if (state_q == S_IDLE) begin
      if (start_i) begin
        pc_q      <= pc_i;
        x_q       <= x_reg_i;
        mode_q    <= mode_i;
        pc_next_q <= pc_i + {14'd0, op_bytes(mode_i)};
        op_lo_q   <= 8'h00;
        op_hi_q   <= 8'h00;
        ind_lo_q  <= 8'h00;
        ind_hi_q  <= 8'h00;
      end
    end else if (mem_ack_i) begin
      case (state_q)
        S_OP_LO:  op_lo_q  <= mem_rdata_i;
        S_OP_HI:  op_hi_q  <= mem_rdata_i;
        S_PTR_LO: ind_lo_q <= mem_rdata_i;
        S_PTR_HI: ind_hi_q <= mem_rdata_i;
        default:  ;
      endcase
    end
  end

  assign operand_lo_o  = op_lo_q;
  assign operand_hi_o  = op_hi_q;
  assign indirect_lo_o = ind_lo_q;
  assign indirect_hi_o = ind_hi_q;
  assign pc_next_o     = pc_next_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_mos6502s_operand_fetcher.sv
// tb/tb_mos6502s_operand_fetcher.sv - randomized self-checking bench for the operand fetcher
module tb_mos6502s_operand_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mode = 4'h0;
  logic [15:0] pc = 16'h0000;
  logic [7:0]  x = 8'h00;
  logic        ack;

  logic        req0, busy0, done0, req1, busy1, done1;
  logic [15:0] addr0, pcn0, addr1, pcn1;
  logic [7:0]  rdata0, lo0, hi0, ilo0, ihi0, rdata1, lo1, hi1, ilo1, ihi1;

  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  assign rdata0 = mem[addr0];
  assign rdata1 = mem[addr1];

  mos6502s_operand_fetcher #(.JMP_IND_BUG(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .pc_i(pc), .x_reg_i(x),
    .mem_req_o(req0), .mem_addr_o(addr0), .mem_ack_i(ack), .mem_rdata_i(rdata0),
    .operand_lo_o(lo0), .operand_hi_o(hi0), .indirect_lo_o(ilo0), .indirect_hi_o(ihi0),
    .pc_next_o(pcn0), .busy_o(busy0), .done_o(done0));

  mos6502s_operand_fetcher #(.JMP_IND_BUG(1'b0)) dut_nobug (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .pc_i(pc), .x_reg_i(x),
    .mem_req_o(req1), .mem_addr_o(addr1), .mem_ack_i(ack), .mem_rdata_i(rdata1),
    .operand_lo_o(lo1), .operand_hi_o(hi1), .indirect_lo_o(ilo1), .indirect_hi_o(ihi1),
    .pc_next_o(pcn1), .busy_o(busy1), .done_o(done1));

  // Memory responder: ack after cfg_wait stall cycles (or a random 0..3 when
  // cfg_wait < 0); spurious acks are thrown in while idle.
  int          cfg_wait = 0;
  int          wcnt = 0, wtgt = 0;
  int          wait_sum = 0, stab_err = 0;
  logic        spur = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] held = 16'h0;
  logic [15:0] log0[$], log1[$];

  assign ack = req0 ? (wcnt >= ((cfg_wait >= 0) ? cfg_wait : wtgt)) : spur;

  always @(posedge clk) begin
    if (rst_n && hold && (!req0 || addr0 !== held)) stab_err++;
    if (!rst_n) begin
      wcnt <= 0;
    end else if (req0) begin
      if (ack) begin
        log0.push_back(addr0);
        log1.push_back(addr1);
        wcnt <= 0;
        wtgt <= $urandom_range(0, 3);
      end else begin
        wcnt <= wcnt + 1;
        wait_sum++;
      end
    end
    hold = rst_n && req0 && !ack;
    held = addr0;
    spur <= (cfg_wait < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected access list and results from the mode rules
  logic [15:0] exp_addr[$], exp1_addr[$];
  int          e_lo, e_hi, e_ilo, e_ihi, e_pcn, e1_ilo, e1_ihi;

  task automatic model(input logic [3:0] m, input logic [15:0] p, input logic [7:0] xv, input bit bug);
    int nb, kind, lo, hi, pa, pb, pi, xi;
    pi = int'(p);
    xi = int'(xv);
    nb = 0; kind = 0; lo = 0; hi = 0;
    case (m)
      4'h2, 4'h3, 4'h4, 4'h5, 4'hC: nb = 1;
      4'h6, 4'h7, 4'h8:             nb = 2;
      4'h9: begin nb = 2; kind = 1; end
      4'hA: begin nb = 1; kind = 2; end
      4'hB: begin nb = 1; kind = 3; end
      default: nb = 0;
    endcase
    exp_addr.delete();
    e_ilo = 0; e_ihi = 0;
    if (nb >= 1) begin exp_addr.push_back(16'(pi)); lo = int'(mem[pi]); end
    if (nb == 2) begin exp_addr.push_back(16'((pi + 1) % 65536)); hi = int'(mem[(pi + 1) % 65536]); end
    if (kind != 0) begin
      if (kind == 2) begin
        pa = (lo + xi) % 256; pb = (lo + xi + 1) % 256;
      end else if (kind == 3) begin
        pa = lo; pb = (lo + 1) % 256;
      end else begin
        pa = hi * 256 + lo;
        pb = bug ? hi * 256 + (lo + 1) % 256 : (pa + 1) % 65536;
      end
      exp_addr.push_back(16'(pa));
      exp_addr.push_back(16'(pb));
      e_ilo = int'(mem[pa]);
      e_ihi = int'(mem[pb]);
    end
    e_lo = lo; e_hi = hi;
    e_pcn = (pi + nb) % 65536;
  endtask

  int last_cyc;

  task automatic run(input logic [3:0] m, input logic [15:0] p, input logic [7:0] xv, input bit garble);
    int i0, w0, s0, cyc;
    model(m, p, xv, 1'b0);
    exp1_addr = exp_addr;
    e1_ilo = e_ilo; e1_ihi = e_ihi;
    model(m, p, xv, 1'b1);
    @(negedge clk);
    i0 = log0.size(); w0 = wait_sum; s0 = stab_err;
    start = 1'b1; mode = m; pc = p; x = xv;
    @(posedge clk); #1;
    start = 1'b0; mode = 4'($urandom); pc = 16'($urandom); x = 8'($urandom);
    cyc = 1;
    while (!done0 && cyc < 60) begin
      if (garble) begin
        start = 1'($urandom_range(0, 1));
        mode = 4'($urandom); pc = 16'($urandom); x = 8'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    last_cyc = cyc;
    check_eq("latency", cyc, exp_addr.size() + 1 + (wait_sum - w0));
    check_eq("done_nobug", done1, 1'b1);
    check_eq("busy_in_done", busy0, 1'b0);
    check_eq("operand", {hi0, lo0}, {e_hi[7:0], e_lo[7:0]});
    check_eq("indirect", {ihi0, ilo0}, {e_ihi[7:0], e_ilo[7:0]});
    check_eq("indirect_nobug", {ihi1, ilo1}, {e1_ihi[7:0], e1_ilo[7:0]});
    check_eq("pc_next", pcn0, e_pcn);
    check_eq("req_stable", stab_err - s0, 0);
    check_eq("n_access", log0.size() - i0, exp_addr.size());
    for (int k = 0; k < exp_addr.size(); k++)
      if (i0 + k < log0.size()) begin
        check_eq("addr", log0[i0 + k], exp_addr[k]);
        check_eq("addr_nobug", log1[i0 + k], exp1_addr[k]);
      end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, {req0, busy0, done0}, 3'b000);
    check_eq({tag, "_addr"}, addr0, 16'h0000);
    check_eq({tag, "_data"}, {lo0, hi0, ilo0, ihi0}, 32'h0);
    check_eq({tag, "_pcn"}, pcn0, 16'h0000);
  endtask

  initial begin
    int i0, n;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Two-byte operand, zero wait
    cfg_wait = 0;
    mem[16'h1234] = 8'h00; mem[16'h1235] = 8'h80;
    run(4'h6, 16'h1234, 8'h00, 1'b0);
    check_eq("t1_operand", {hi0, lo0}, 16'h8000);
    check_eq("t1_pcn", pcn0, 16'h1236);
    check_eq("t1_lat", last_cyc, 3);

    // JMP (abs) page-wrap bug vs. fixed pointer increment
    mem[16'h0200] = 8'hFF; mem[16'h0201] = 8'h10;
    mem[16'h10FF] = 8'h34; mem[16'h1000] = 8'h12; mem[16'h1100] = 8'h56;
    i0 = log0.size();
    run(4'h9, 16'h0200, 8'h00, 1'b0);
    check_eq("t2_ind", {ihi0, ilo0}, 16'h1234);
    check_eq("t2_ind_nobug", {ihi1, ilo1}, 16'h5634);
    if (log0.size() >= i0 + 4) begin
      check_eq("t2_4th", log0[i0 + 3], 16'h1000);
      check_eq("t2_4th_nobug", log1[i0 + 3], 16'h1100);
    end

    // Zero-page pointer wrap
    mem[16'h0300] = 8'hFE;
    i0 = log0.size();
    run(4'hA, 16'h0300, 8'h01, 1'b0);
    if (log0.size() >= i0 + 3) check_eq("t3_zpx", {log0[i0 + 1], log0[i0 + 2]}, 32'h00FF_0000);
    mem[16'h0400] = 8'hFF;
    i0 = log0.size();
    run(4'hB, 16'h0400, 8'h77, 1'b0);
    if (log0.size() >= i0 + 3) check_eq("t3_zpy", {log0[i0 + 1], log0[i0 + 2]}, 32'h00FF_0000);
    check_eq("t3_pcn", pcn0, 16'h0401);

    // Three wait cycles per access
    cfg_wait = 3;
    run(4'h7, 16'hFFFF, 8'h00, 1'b1);
    check_eq("t4_lat", last_cyc, 9);
    @(posedge clk); #1;
    check_eq("t4_pulse", {done0, busy0}, 2'b00);

    // No-operand modes back to back, second start in the done cycle
    cfg_wait = 0;
    run(4'h0, 16'h4321, 8'h00, 1'b0);
    check_eq("t5_lat0", last_cyc, 1);
    run(4'hD, 16'h5555, 8'h00, 1'b0);
    check_eq("t5_latD", last_cyc, 1);
    check_eq("t5_pcn", pcn0, 16'h5555);

    // Reset during OP_HI
    cfg_wait = 4;
    @(negedge clk);
    i0 = log0.size();
    start = 1'b1; mode = 4'h6; pc = 16'h5000;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (log0.size() == i0 && n < 40) begin @(negedge clk); n++; end
    check_eq("t6_reach_ophi", (log0.size() > i0) ? 1 : 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cfg_wait = 1;
    run(4'h8, 16'h5000, 8'h00, 1'b0);

    // Randomized transactions with random waits, spurious acks and busy starts
    cfg_wait = -1;
    for (int t = 0; t < 200; t++)
      run(4'($urandom), ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom), 8'($urandom), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
